result_transmitter: RTL and testbench

Return-path framer for the UART calculator. It takes one computed result plus the operation code that produced it, builds a fixed 4-byte response frame, and feeds the frame byte by byte to the UART transmitter over a start/busy handshake. It sits between the ALU output and the UART TX. It is the outbound counterpart of the command collector that assembles `operation`, `data_a` and `data_b` from received bytes.

---
 rtl/result_transmitter_pkg.sv | 23 ++
 rtl/result_transmitter_if.sv | 22 ++
 rtl/result_transmitter.sv | 95 +++++++++
 tb/tb_result_transmitter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_transmitter_pkg.sv
// Shared definitions for the UART calculator framing logic: transmitter states,
// frame layout and the checksum that both directions agree on.
package uart_calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    HOLD
  } tx_state_t;

  localparam int FRAME_LEN = 4;

  localparam logic [1:0] BYTE_OP     = 2'd0;
  localparam logic [1:0] BYTE_RES_HI = 2'd1;
  localparam logic [1:0] BYTE_RES_LO = 2'd2;
  localparam logic [1:0] BYTE_CSUM   = 2'd3;

  function automatic logic [7:0] frame_checksum(input logic [7:0] op, input logic [15:0] res);
    return op ^ res[15:8] ^ res[7:0];
  endfunction

endpackage

// File: rtl/result_transmitter_if.sv
// Result-in / byte-out handshake bundle of the response framer.
// master is the framer itself; slave is the ALU plus UART TX side.
interface result_transmitter_if;
  logic        result_valid;
  logic [15:0] result;
  logic [7:0]  operation;
  logic        result_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_done;

  modport master (
    input  result_valid, result, operation, tx_busy,
    output result_ready, tx_start, tx_data, frame_done
  );

  modport slave (
    output result_valid, result, operation, tx_busy,
    input  result_ready, tx_start, tx_data, frame_done
  );
endinterface

// File: rtl/result_transmitter.sv
// Builds the 4-byte response frame (op, res_hi, res_lo, checksum) and hands it
// to the UART TX one byte at a time over the tx_start / tx_busy handshake.
module result_transmitter
  import uart_calc_pkg::*;
#(
  parameter int FRAME_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  result_transmitter_if.master  bus
);

  localparam logic [2:0] FRAME_END = 3'(FRAME_BYTES);

  tx_state_t   state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  op_reg, op_next;
  logic [15:0] res_reg, res_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        frame_done_reg, frame_done_next;
  logic [7:0]  byte_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= 3'd0;
      op_reg         <= 8'h00;
      res_reg        <= 16'h0000;
      tx_data_reg    <= 8'h00;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      op_reg         <= op_next;
      res_reg        <= res_next;
      tx_data_reg    <= tx_data_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    case (idx_reg[1:0])
      BYTE_OP:     byte_sel = op_reg;
      BYTE_RES_HI: byte_sel = res_reg[15:8];
      BYTE_RES_LO: byte_sel = res_reg[7:0];
      default:     byte_sel = frame_checksum(op_reg, res_reg);
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    op_next         = op_reg;
    res_next        = res_reg;
    tx_data_next    = tx_data_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.result_valid) begin
          op_next    = bus.operation;
          res_next   = bus.result;
          idx_next   = 3'd0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!bus.tx_busy) begin
          if (idx_reg < FRAME_END) begin
            // tx_data is only ever reloaded on the edge into SEND
            tx_data_next = byte_sel;
            state_next   = SEND;
          end else begin
            frame_done_next = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      SEND: begin
        state_next = HOLD;
        if (idx_reg < FRAME_END) idx_next = idx_reg + 3'd1;
      end
      HOLD: begin
        // one guard cycle so the UART's late tx_busy rise is seen in WAIT
        state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.result_ready = (state_reg == IDLE);
  assign bus.tx_start     = (state_reg == SEND);
  assign bus.tx_data      = tx_data_reg;
  assign bus.frame_done   = frame_done_reg;

endmodule

// File: tb/tb_result_transmitter.sv
// Bench for result_transmitter: UART busy model, timing-rule reference model with
// per-cycle compare, directed frames with literal byte checks, then random traffic.
module tb_result_transmitter;

  logic clk;
  logic reset;
  result_transmitter_if bus();

  result_transmitter #(.FRAME_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int uart_len = 10;
  logic force_busy = 1'b0;
  int start_count = 0;
  int done_count = 0;
  logic [7:0] sent_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // UART TX model: busy rises the cycle after tx_start and lasts uart_len cycles
  initial begin
    int busy_cnt;
    logic st;
    busy_cnt = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      st = bus.tx_start;
      @(posedge clk);
      #2;
      if (busy_cnt > 0) busy_cnt--;
      if (st === 1'b1) busy_cnt = uart_len;
      bus.tx_busy = (busy_cnt > 0) || force_busy;
    end
  end

  // Reference model: frame content plus the earliest-cycle timing rules
  initial begin : compare
    int t;
    bit armed;
    bit m_idle;
    int m_sent;
    int m_earliest;
    logic m_prev_busy;
    logic [7:0] m_last;
    logic [7:0] m_frame[4];
    logic exp_start, exp_done, exp_ready;
    logic [7:0] exp_data;
    t = 0; armed = 0; m_idle = 1; m_sent = 0; m_earliest = 0;
    m_prev_busy = 0; m_last = 8'h00;
    forever begin
      @(negedge clk);
      t++;
      if (bus.tx_start === 1'b1) begin
        start_count++;
        sent_log.push_back(bus.tx_data);
      end
      if (bus.frame_done === 1'b1) done_count++;
      if (reset === 1'b1) begin
        armed = 1; m_idle = 1; m_sent = 0; m_last = 8'h00;
      end else if (armed) begin
        exp_start = 0;
        exp_done = 0;
        if (!m_idle && t >= m_earliest && !m_prev_busy) begin
          if (m_sent < 4) exp_start = 1;
          else begin
            exp_done = 1;
            m_idle = 1;
          end
        end
        exp_ready = m_idle;
        exp_data = exp_start ? m_frame[m_sent] : m_last;
        chk("result_ready", bus.result_ready, exp_ready);
        chk("tx_start", bus.tx_start, exp_start);
        chk("frame_done", bus.frame_done, exp_done);
        chk("tx_data", bus.tx_data, exp_data);
        if (exp_start) begin
          m_last = m_frame[m_sent];
          m_sent++;
          m_earliest = t + 3;
        end
        if (m_idle && bus.result_valid === 1'b1) begin
          m_frame[0] = bus.operation;
          m_frame[1] = bus.result[15:8];
          m_frame[2] = bus.result[7:0];
          m_frame[3] = bus.operation ^ bus.result[15:8] ^ bus.result[7:0];
          m_idle = 0;
          m_sent = 0;
          m_earliest = t + 2;
        end
      end
      m_prev_busy = bus.tx_busy;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 400 && bus.result_ready !== 1'b1; i++) step(1);
    if (bus.result_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 400 && done_count <= prev; i++) step(1);
    if (done_count <= prev) chk("done_timeout", done_count, prev + 1);
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 400 && start_count < target; i++) step(1);
    if (start_count < target) chk("start_timeout", start_count, target);
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] res);
    wait_ready();
    bus.result_valid = 1'b1;
    bus.operation = op;
    bus.result = res;
    step(1);
    bus.result_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input int base,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    logic [7:0] a;
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      a = (base + i < sent_log.size()) ? sent_log[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", name, i), a, e[i]);
    end
  endtask

  initial begin : stimulus
    int s0, d0;
    reset = 1'b1;
    bus.result_valid = 1'b0;
    bus.operation = 8'h00;
    bus.result = 16'h0000;
    step(3);
    reset = 1'b0;
    chk("reset_ready", bus.result_ready, 1);
    chk("reset_tx_start", bus.tx_start, 0);
    chk("reset_tx_data", bus.tx_data, 8'h00);
    chk("reset_frame_done", bus.frame_done, 0);
    chk("pkg_checksum", uart_calc_pkg::frame_checksum(8'h01, 16'h1234), 8'h27);
    step(2);

    // basic frame
    sent_log.delete(); s0 = start_count; d0 = done_count;
    send(8'h01, 16'h1234);
    wait_done(d0);
    step(5);
    check_log("basic", 0, 8'h01, 8'h12, 8'h34, 8'h27);
    chk("basic_starts", start_count - s0, 4);
    chk("basic_dones", done_count - d0, 1);
    $display("frame basic op=01 res=1234 bytes=%0d", sent_log.size());

    // checksum corner cases
    sent_log.delete(); d0 = done_count;
    send(8'hFF, 16'hFF00);
    wait_done(d0);
    check_log("ones", 0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    $display("frame ones op=FF res=FF00");
    sent_log.delete(); d0 = done_count;
    send(8'h00, 16'h0000);
    wait_done(d0);
    check_log("zeros", 0, 8'h00, 8'h00, 8'h00, 8'h00);
    $display("frame zeros op=00 res=0000");

    // UART busy while the frame is accepted
    sent_log.delete(); d0 = done_count;
    wait_ready();
    force_busy = 1'b1;
    bus.result_valid = 1'b1; bus.operation = 8'h03; bus.result = 16'hABCD;
    step(1);
    bus.result_valid = 1'b0;
    step(7);
    force_busy = 1'b0;
    wait_done(d0);
    check_log("busy_accept", 0, 8'h03, 8'hAB, 8'hCD, 8'h65);
    $display("frame busy_accept op=03 res=ABCD");

    // result offered mid-frame must be dropped
    sent_log.delete(); s0 = start_count; d0 = done_count;
    send(8'h02, 16'h1111);
    wait_starts(s0 + 2);
    bus.result_valid = 1'b1; bus.operation = 8'h99; bus.result = 16'h5555;
    step(1);
    bus.result_valid = 1'b0;
    wait_done(d0);
    step(30);
    check_log("dropped", 0, 8'h02, 8'h11, 8'h11, 8'h02);
    chk("dropped_starts", start_count - s0, 4);
    chk("dropped_dones", done_count - d0, 1);
    $display("frame dropped op=02 res=1111 (5555 ignored)");

    // reset after the second byte
    sent_log.delete(); s0 = start_count; d0 = done_count;
    send(8'h04, 16'h5678);
    wait_starts(s0 + 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midreset_ready", bus.result_ready, 1);
    chk("midreset_tx_start", bus.tx_start, 0);
    chk("midreset_tx_data", bus.tx_data, 8'h00);
    step(40);
    chk("midreset_no_done", done_count - d0, 0);
    sent_log.delete(); d0 = done_count;
    send(8'h05, 16'h00FF);
    wait_done(d0);
    check_log("after_reset", 0, 8'h05, 8'h00, 8'hFF, 8'hFA);
    $display("frame after_reset op=05 res=00FF");

    // back-to-back frames with result_valid held high
    sent_log.delete(); d0 = done_count;
    wait_ready();
    bus.result_valid = 1'b1; bus.operation = 8'h10; bus.result = 16'h0102;
    step(1);
    bus.result = 16'h0304;
    wait_done(d0);
    bus.result_valid = 1'b0;
    wait_done(d0 + 1);
    step(5);
    chk("b2b_dones", done_count - d0, 2);
    check_log("b2b_first", 0, 8'h10, 8'h01, 8'h02, 8'h13);
    check_log("b2b_second", 4, 8'h10, 8'h03, 8'h04, 8'h17);
    $display("frame b2b res=0102,0304 bytes=%0d", sent_log.size());

    // random traffic against the model
    for (int blk = 0; blk < 16; blk++) begin
      uart_len = $urandom_range(0, 12);
      for (int i = 0; i < 50; i++) begin
        bus.result_valid = ($urandom_range(0, 3) == 0);
        bus.operation = 8'($urandom);
        bus.result = 16'($urandom);
        step(1);
      end
      $display("random block %0d uart_len=%0d starts=%0d dones=%0d", blk, uart_len, start_count, done_count);
    end
    bus.result_valid = 1'b0;
    for (int i = 0; i < 200 && !(bus.result_ready === 1'b1 && bus.tx_busy === 1'b0); i++) step(1);
    chk("final_idle", bus.result_ready, 1);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
